// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl
//   Program-counter and fetch sequencing stage. Presents the branch-table
//   index combinationally, takes the table's target back in the same cycle,
//   and registers the next fetch address (sequential, absolute or
//   PC-relative). A small IDLE/RUN/HALT machine gates fetch_valid and done
//   and counts taken branches with saturation.
//
// Ports
//   clk         system clock, all state on rising edge
//   reset       synchronous, active-high
//   start       begin execution at address 0 (accepted in IDLE/HALT only)
//   stall       hold PC this cycle (RUN)
//   halt_req    halt instruction in current fetch slot (RUN)
//   branch_abs  take branch, next PC = target
//   branch_rel  take branch, next PC = prog_ctr + signed(target)
//   lut_idx     branch-table index field of current instruction
//   lut_addr    index to branch-target table (= lut_idx, combinational)
//   target      table output for lut_addr, same cycle
//   prog_ctr    current fetch address
//   fetch_valid prog_ctr addresses a live instruction
//   done        program halted
//   taken_cnt   taken branches since start, saturating

module pc_fetch_ctrl #(
  parameter int D  = 10,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stall,
  input  logic          halt_req,
  input  logic          branch_abs,
  input  logic          branch_rel,
  input  logic [3:0]    lut_idx,
  output logic [3:0]    lut_addr,
  input  logic [D-1:0]  target,
  output logic [D-1:0]  prog_ctr,
  output logic          fetch_valid,
  output logic          done,
  output logic [CW-1:0] taken_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

  state_t        state_q;
  logic [D-1:0]  pc_q;
  logic          fv_q;
  logic          done_q;
  logic [CW-1:0] cnt_q;

  // Next PC and count for an unstalled RUN cycle without halt.
  logic [D-1:0]  pc_d;
  logic [CW-1:0] cnt_d;
  logic          taken;

  assign lut_addr = lut_idx;

  always_comb begin
    taken = branch_abs | branch_rel;
    pc_d  = pc_q + D'(1);
    if (branch_abs)      pc_d = target;
    // Two's-complement add: modular D-bit sum wraps in both directions.
    else if (branch_rel) pc_d = pc_q + target;
    cnt_d = cnt_q;
    if (taken && (cnt_q != {CW{1'b1}})) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      fv_q    <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE, HALT: begin
          // Branch/stall/halt inputs are ignored outside RUN.
          if (start) begin
            state_q <= RUN;
            pc_q    <= '0;
            fv_q    <= 1'b1;
            done_q  <= 1'b0;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          if (halt_req) begin
            // PC freezes at the halt instruction's address.
            state_q <= HALT;
            fv_q    <= 1'b0;
            done_q  <= 1'b1;
          end else if (!stall) begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= IDLE;
          pc_q    <= '0;
          fv_q    <= 1'b0;
          done_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign prog_ctr    = pc_q;
  assign fetch_valid = fv_q;
  assign done        = done_q;
  assign taken_cnt   = cnt_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios followed by random cycles.
// A behavioural model predicts the post-edge outputs of every cycle and
// queues them; a monitor pops and compares after each rising edge. A
// second instance with CW=2 runs on the same stimulus to exercise
// counter saturation.

module tb_pc_fetch_ctrl;
  localparam int D = 10;

  logic         clk = 1'b0;
  logic         reset, start, stall, halt_req, branch_abs, branch_rel;
  logic [3:0]   lut_idx, lut_addr, lut_addr2;
  logic [D-1:0] target, prog_ctr, prog_ctr2;
  logic         fetch_valid, done, fetch_valid2, done2;
  logic [7:0]   taken_cnt;
  logic [1:0]   taken_cnt2;
  logic [D-1:0] lut [16];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign target = lut[lut_addr];

  pc_fetch_ctrl #(.D(D), .CW(8)) u_dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .halt_req(halt_req),
    .branch_abs(branch_abs), .branch_rel(branch_rel), .lut_idx(lut_idx),
    .lut_addr(lut_addr), .target(target), .prog_ctr(prog_ctr),
    .fetch_valid(fetch_valid), .done(done), .taken_cnt(taken_cnt));

  pc_fetch_ctrl #(.D(D), .CW(2)) u_sat (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .halt_req(halt_req),
    .branch_abs(branch_abs), .branch_rel(branch_rel), .lut_idx(lut_idx),
    .lut_addr(lut_addr2), .target(target), .prog_ctr(prog_ctr2),
    .fetch_valid(fetch_valid2), .done(done2), .taken_cnt(taken_cnt2));

  typedef struct {
    int pc; int fv; int dn; int cnt; int cnt2;
  } exp_t;
  exp_t sb[$];

  // Reference model: "running" / "halted" flags, integer PC and counts.
  bit m_run = 0, m_halted = 0;
  int m_pc = 0, m_cnt = 0, m_cnt2 = 0;

  function automatic int sext(input int t);
    return (t >= (1 << (D-1))) ? t - (1 << D) : t;
  endfunction

  task automatic model_step(input bit r, input bit s, input bit st, input bit h,
                            input bit ba, input bit br, input int t);
    if (r) begin
      m_run = 0; m_halted = 0; m_pc = 0; m_cnt = 0; m_cnt2 = 0;
    end else if (!m_run) begin
      if (s) begin m_run = 1; m_halted = 0; m_pc = 0; m_cnt = 0; m_cnt2 = 0; end
    end else if (h) begin
      m_run = 0; m_halted = 1;
    end else if (!st) begin
      if (ba || br) begin
        m_pc   = ba ? t : (((m_pc + sext(t)) % 1024) + 1024) % 1024;
        m_cnt  = (m_cnt  < 255) ? m_cnt  + 1 : 255;
        m_cnt2 = (m_cnt2 < 3)   ? m_cnt2 + 1 : 3;
      end else begin
        m_pc = (m_pc + 1) % 1024;
      end
    end
    sb.push_back('{m_pc, int'(m_run), int'(m_halted), m_cnt, m_cnt2});
  endtask

  task automatic cmp(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // One clock of stimulus, applied at the falling edge.
  task automatic cyc(input bit r = 0, input bit s = 0, input bit st = 0,
                     input bit h = 0, input bit ba = 0, input bit br = 0,
                     input int idx = 0);
    @(negedge clk);
    reset = r; start = s; stall = st; halt_req = h;
    branch_abs = ba; branch_rel = br; lut_idx = 4'(idx);
    #1;
    cmp("lut_addr", int'(lut_addr), idx);
    cmp("lut_addr_sat", int'(lut_addr2), idx);
    model_step(r, s, st, h, ba, br, int'(lut[idx]));
  endtask

  // Directed check of DUT outputs right after the edge just issued.
  task automatic expect_out(input string name, input int pc, input int fv,
                            input int dn, input int cnt);
    @(posedge clk); #2;
    cmp({name, ".pc"}, int'(prog_ctr), pc);
    cmp({name, ".fv"}, int'(fetch_valid), fv);
    cmp({name, ".done"}, int'(done), dn);
    cmp({name, ".cnt"}, int'(taken_cnt), cnt);
  endtask

  // Scoreboard monitor.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      cmp("sb.pc",   int'(prog_ctr),     e.pc);
      cmp("sb.fv",   int'(fetch_valid),  e.fv);
      cmp("sb.done", int'(done),         e.dn);
      cmp("sb.cnt",  int'(taken_cnt),    e.cnt);
      cmp("sb.pc2",  int'(prog_ctr2),    e.pc);
      cmp("sb.cnt2", int'(taken_cnt2),   e.cnt2);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; start = 0; stall = 0; halt_req = 0;
    branch_abs = 0; branch_rel = 0; lut_idx = 0;
    for (int i = 0; i < 16; i++) lut[i] = D'($urandom_range(0, 1023));
    lut[0] = 0; lut[1] = 10; lut[2] = 44; lut[3] = 105;
    lut[5] = 1023; lut[6] = 20; lut[7] = 1019; lut[8] = 2;
    lut[9] = 50;   lut[10] = 77;

    // Reset state, then IDLE ignores branch/halt/stall.
    cyc(.r(1)); expect_out("reset", 0, 0, 0, 0);
    cyc(.ba(1), .idx(3)); cyc(.h(1)); cyc(.st(1), .br(1), .idx(5));
    expect_out("idle_hold", 0, 0, 0, 0);

    // Start and sequential fetch.
    cyc(.s(1)); expect_out("start", 0, 1, 0, 0);
    cyc(); expect_out("seq1", 1, 1, 0, 0);
    cyc(.s(1)); expect_out("seq2_start_ignored", 2, 1, 0, 0);
    cyc(.ba(1), .idx(3)); expect_out("abs105", 105, 1, 0, 1);

    // Relative branches.
    cyc(.r(1)); cyc(.s(1));
    repeat (4) cyc();
    cyc(.br(1), .idx(5)); expect_out("rel_m1", 3, 1, 0, 1);
    cyc();
    cyc(.br(1), .idx(6)); expect_out("rel_p20", 24, 1, 0, 2);
    cyc(.ba(1), .idx(8));
    cyc(.br(1), .idx(7)); expect_out("rel_wrap", 1021, 1, 0, 4);
    cyc(); cyc();
    cyc(); expect_out("inc_wrap", 0, 1, 0, 4);

    // Simultaneous events.
    cyc(.st(1), .ba(1), .idx(3)); expect_out("stall_abs", 0, 1, 0, 4);
    cyc(.ba(1), .br(1), .idx(1)); expect_out("abs_and_rel", 10, 1, 0, 5);
    cyc(.ba(1), .idx(9));
    cyc(.h(1), .st(1), .br(1), .idx(6)); expect_out("halt", 50, 0, 1, 6);

    // HALT ignores flags; restart clears.
    cyc(.ba(1), .idx(3)); cyc(.br(1), .idx(5)); cyc(.st(1)); cyc(.h(1));
    expect_out("halt_hold", 50, 0, 1, 6);
    cyc(.s(1)); expect_out("restart", 0, 1, 0, 0);
    cyc(.ba(1), .idx(10));
    cyc(.r(1), .s(1), .ba(1), .idx(3)); expect_out("reset_run", 0, 0, 0, 0);

    // Saturation: CW=2 instance reaches 3 after five branches.
    cyc(.s(1));
    repeat (5) cyc(.ba(1), .idx(1));
    expect_out("sat5", 10, 1, 0, 5);
    checks++;
    if (taken_cnt2 != 2'd3) begin
      errors++;
      $display("FAIL sat_cw2: got %0d expected 3", taken_cnt2);
    end

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      automatic int rr = $urandom_range(0, 99);
      cyc(.r(rr < 2), .s($urandom_range(0, 9) == 0), .st($urandom_range(0, 4) == 0),
          .h($urandom_range(0, 24) == 0), .ba($urandom_range(0, 3) == 0),
          .br($urandom_range(0, 2) == 0), .idx($urandom_range(0, 15)));
    end

    cyc();
    @(posedge clk); #3;
    cmp("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Program-counter and fetch-sequencing stage that consumes the branch-target lookup table. It drives a 4-bit table index and receives a D-bit target in the same cycle. It registers the next program counter: sequential, absolute branch, or PC-relative branch. It also runs a start/run/halt state machine for the instruction memory and the done handshake to the testbench.

Parameters:
D, 10, program counter width; instruction memory depth is 2**D
CW, 8, width of the taken-branch counter

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  begin execution from address 0 (IDLE or HALT only)
stall  input  1  hold program counter this cycle
halt_req  input  1  decoded halt instruction in the current fetch slot
branch_abs  input  1  take branch; next PC = target
branch_rel  input  1  take branch; next PC = prog_ctr + signed(target)
lut_idx  input  4  branch-table index field from the current instruction
lut_addr  output  4  index presented to the branch-target table
target  input  D  table output for lut_addr, valid in the same cycle
prog_ctr  output  D  current fetch address
fetch_valid  output  1  high while prog_ctr addresses a live instruction
done  output  1  program halted
taken_cnt  output  CW  number of taken branches since start

Behaviour:
- lut_addr = lut_idx, combinational, in all states; target is sampled in the same cycle.
- All other outputs are registered.
- Reset (sync, high) forces:
  - state IDLE
  - prog_ctr 0
  - fetch_valid 0
  - done 0
  - taken_cnt 0
- Reset overrides every other input in the same cycle, including mid-RUN and in HALT.
- States:
  - IDLE: PC held at 0, fetch_valid 0, done 0. start -> RUN; fetch_valid rises the next cycle with prog_ctr 0.
  - RUN: fetch_valid 1, done 0. PC update per priority below.
  - HALT: fetch_valid 0, done 1, prog_ctr frozen at the halt instruction's address. start -> RUN with prog_ctr 0, taken_cnt 0, done 0 the next cycle.
- In IDLE and HALT, stall, halt_req and branch flags are ignored.
- RUN priority, highest first, evaluated each cycle:
  1. halt_req -> HALT; PC unchanged; no branch counted, even if stall or branch flags are asserted.
  2. stall -> PC and taken_cnt unchanged.
  3. branch_abs -> next PC = target.
  4. branch_rel -> next PC = (prog_ctr + target) mod 2**D, with target read as two's-complement D-bit. For example, target 1023 = -1 and 1019 = -5.
  5. otherwise next PC = (prog_ctr + 1) mod 2**D.
- branch_abs and branch_rel both high: absolute wins; counted once.
- Latency: one cycle. Branch asserted in cycle n -> prog_ctr equals the new value after edge n+1; no delay slot.
- Wrap-around: the increment from 2**D-1 goes to 0 with no flag. A relative branch that over- or under-flows wraps modulo 2**D.
- taken_cnt increments on each taken (unstalled) branch in RUN and saturates at 2**CW-1.
- start asserted while in RUN is ignored.

Test Plan:
- Reset, then start: prog_ctr 0,1,2,3 on consecutive cycles; fetch_valid 1 from the first cycle after start; done 0.
- Table loaded with 0,10,44,105,...; at PC 2 assert branch_abs with lut_idx 3 -> lut_addr 3 same cycle; prog_ctr 105 next cycle; taken_cnt 1.
- Relative: at PC 4 target 1023 -> PC 3. At PC 4 target 20 -> PC 24. At PC 2 target 1019 -> PC 1021 (wrap). At PC 1023 with no branch -> PC 0.
- Simultaneous events:
  - stall + branch_abs -> PC held, taken_cnt unchanged.
  - halt_req + stall + branch_rel at PC 50 -> HALT, prog_ctr 50, done 1, fetch_valid 0.
  - branch_abs + branch_rel -> target used, taken_cnt +1.
- Halt/restart: in HALT toggle branch flags -> no change. Pulse start -> prog_ctr 0, done 0, taken_cnt 0. Pulse reset mid-RUN at PC 77 -> IDLE, prog_ctr 0 next cycle.
- Saturation with CW=2: five taken branches -> taken_cnt 3.
